// File: rtl/vga_coord_generator.sv
// Free-running VGA timing generator: pixel/line counters plus registered sync,
// active-video and end-of-line/frame flags aligned with the coordinates.
module vga_coord_generator #(
    parameter int unsigned H_VISIBLE = 1280,
    parameter int unsigned H_FP      = 48,
    parameter int unsigned H_SYNC    = 112,
    parameter int unsigned H_BP      = 248,
    parameter int unsigned V_VISIBLE = 1024,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BP      = 38,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1
) (
    input  logic        CLK_VGA,
    input  logic        RESET,
    input  logic        PIX_EN,
    output logic [11:0] VGA_horzCoord,
    output logic [11:0] VGA_vertCoord,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_ACTIVE,
    output logic        LINE_END,
    output logic        FRAME_END
);

    localparam int unsigned CW           = 12;
    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_timing
            $error("vga_coord_generator: H_TOTAL/V_TOTAL must be in 1..4096");
        end
    endgenerate

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          act_q, act_d;
    logic          le_q, le_d;
    logic          fe_q, fe_d;

    // One guard bit so window ends equal to 4096 still compare correctly.
    logic [CW:0]   h_ext;
    logic [CW:0]   v_ext;

    // Next coordinates, then flags decoded from them so they stay aligned.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (PIX_EN) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
            end else begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end

        h_ext = {1'b0, hcnt_d};
        v_ext = {1'b0, vcnt_d};

        hs_d  = ((h_ext >= (CW+1)'(H_SYNC_START)) && (h_ext < (CW+1)'(H_SYNC_END))) ? HS_POL : ~HS_POL;
        vs_d  = ((v_ext >= (CW+1)'(V_SYNC_START)) && (v_ext < (CW+1)'(V_SYNC_END))) ? VS_POL : ~VS_POL;
        act_d = (h_ext < (CW+1)'(H_VISIBLE)) && (v_ext < (CW+1)'(V_VISIBLE));
        le_d  = (hcnt_d == H_LAST);
        fe_d  = le_d && (vcnt_d == V_LAST);
    end

    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            act_q  <= 1'b1;
            le_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            act_q  <= act_d;
            le_q   <= le_d;
            fe_q   <= fe_d;
        end
    end

    assign VGA_horzCoord = hcnt_q;
    assign VGA_vertCoord = vcnt_q;
    assign VGA_HS        = hs_q;
    assign VGA_VS        = vs_q;
    assign VGA_ACTIVE    = act_q;
    assign LINE_END      = le_q;
    assign FRAME_END     = fe_q;

endmodule

// File: tb/tb_vga_coord_generator.sv
// Bench for vga_coord_generator: default timing for line-level behaviour and a
// tiny inverted-polarity instance for frame-level wrap, VS and reset behaviour.
module tb_vga_coord_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default 1280x1024 timing
    logic        rst_a = 1'b1, en_a = 1'b0;
    logic [11:0] h_a, v_a;
    logic        hs_a, vs_a, act_a, le_a, fe_a;

    vga_coord_generator u_dut_a (
        .CLK_VGA(clk), .RESET(rst_a), .PIX_EN(en_a),
        .VGA_horzCoord(h_a), .VGA_vertCoord(v_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_ACTIVE(act_a),
        .LINE_END(le_a), .FRAME_END(fe_a)
    );

    // Instance B: H 8/2/2/2, V 4/1/1/1, active-low syncs
    logic        rst_b = 1'b1, en_b = 1'b0;
    logic [11:0] h_b, v_b;
    logic        hs_b, vs_b, act_b, le_b, fe_b;

    vga_coord_generator #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_b (
        .CLK_VGA(clk), .RESET(rst_b), .PIX_EN(en_b),
        .VGA_horzCoord(h_b), .VGA_vertCoord(v_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_ACTIVE(act_b),
        .LINE_END(le_b), .FRAME_END(fe_b)
    );

    int tests = 0;
    int fails = 0;

    logic [28:0] q_a[$];
    logic [28:0] q_b[$];
    int mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;

    // Expected {h, v, hs, vs, active, line_end, frame_end} for a coordinate.
    function automatic logic [28:0] exp_of(int h, int v, int hv, int hf, int hsw, int hb,
                                           int vv, int vf, int vsw, int vb, bit hp, bit vp);
        int  ht = hv + hf + hsw + hb;
        int  vt = vv + vf + vsw + vb;
        bit  hs = (h >= hv + hf && h < hv + hf + hsw) ? hp : !hp;
        bit  vs = (v >= vv + vf && v < vv + vf + vsw) ? vp : !vp;
        bit  act = (h < hv) && (v < vv);
        bit  le = (h == ht - 1);
        bit  fe = le && (v == vt - 1);
        return {12'(h), 12'(v), hs, vs, act, le, fe};
    endfunction

    task automatic advance(inout int h, inout int v, input int ht, input int vt);
        if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic sb_check(input string tag, input logic [28:0] obs, inout logic [28:0] q[$]);
        logic [28:0] e;
        if (q.size() == 0) begin
            fails++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
            return;
        end
        e = q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic tick_a(input logic rst, input logic en);
        rst_a = rst;
        en_a  = en;
        if (rst) begin
            mh_a = 0; mv_a = 0;
        end else if (en) begin
            advance(mh_a, mv_a, 1688, 1066);
        end
        q_a.push_back(exp_of(mh_a, mv_a, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        sb_check("sb_a", {h_a, v_a, hs_a, vs_a, act_a, le_a, fe_a}, q_a);
    endtask

    task automatic tick_b(input logic rst, input logic en);
        rst_b = rst;
        en_b  = en;
        if (rst) begin
            mh_b = 0; mv_b = 0;
        end else if (en) begin
            advance(mh_b, mv_b, 14, 7);
        end
        q_b.push_back(exp_of(mh_b, mv_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        sb_check("sb_b", {h_b, v_b, hs_b, vs_b, act_b, le_b, fe_b}, q_b);
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, act_fall, le_h, le_cnt, n;
        int fe_cnt, vs_cnt, hs_low, hs_low_bad, max_h, max_v;

        @(posedge clk);
        #1;

        // Reset held, then a single enabled pixel
        repeat (5) tick_a(1'b1, 1'b1);
        chk("rst_hold_h", 32'(h_a), 0);
        chk("rst_hold_v", 32'(v_a), 0);
        chk("rst_active", 32'(act_a), 1);
        tick_a(1'b0, 1'b1);
        chk("first_px_h", 32'(h_a), 1);
        chk("first_px_v", 32'(v_a), 0);
        chk("first_px_hs", 32'(hs_a), 0);
        chk("first_px_vs", 32'(vs_a), 0);

        // One full line
        hs_cnt = 0; hs_first = -1; hs_last = -1; act_fall = -1; le_h = -1; le_cnt = 0;
        for (int i = 0; i < 2000 && le_h < 0; i++) begin
            tick_a(1'b0, 1'b1);
            if (hs_a) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = 32'(h_a);
                hs_last = 32'(h_a);
            end
            if (!act_a && act_fall < 0) act_fall = 32'(h_a);
            if (le_a) begin
                le_cnt++;
                le_h = 32'(h_a);
            end
        end
        chk("hs_width", 32'(hs_cnt), 112);
        chk("hs_first", 32'(hs_first), 1328);
        chk("hs_last", 32'(hs_last), 1439);
        chk("active_fall", 32'(act_fall), 1280);
        chk("line_end_h", 32'(le_h), 1687);
        chk("line_end_cnt", 32'(le_cnt), 1);
        tick_a(1'b0, 1'b1);
        chk("line_wrap_h", 32'(h_a), 0);
        chk("line_wrap_v", 32'(v_a), 1);
        chk("line_wrap_le", 32'(le_a), 0);

        // Freeze with PIX_EN low at hcnt 500
        for (int i = 0; i < 600 && h_a != 12'd500; i++) tick_a(1'b0, 1'b1);
        repeat (7) tick_a(1'b0, 1'b0);
        chk("freeze_h", 32'(h_a), 500);
        chk("freeze_v", 32'(v_a), 1);
        tick_a(1'b0, 1'b1);
        chk("resume_h", 32'(h_a), 501);

        // Small instance: two full frames
        repeat (2) tick_b(1'b1, 1'b1);
        fe_cnt = 0; vs_cnt = 0; hs_low = 0; hs_low_bad = 0; max_h = 0; max_v = 0;
        for (int i = 0; i < 2 * 98; i++) begin
            tick_b(1'b0, 1'b1);
            if (fe_b) fe_cnt++;
            if (!vs_b) vs_cnt++;
            if (!hs_b) begin
                hs_low++;
                if (h_b < 12'd10 || h_b > 12'd11) hs_low_bad++;
            end
            if (32'(h_b) > max_h) max_h = 32'(h_b);
            if (32'(v_b) > max_v) max_v = 32'(v_b);
        end
        chk("b_frame_end_cnt", 32'(fe_cnt), 2);
        chk("b_vs_cycles", 32'(vs_cnt), 28);
        chk("b_hs_low_cycles", 32'(hs_low), 28);
        chk("b_hs_low_outside", 32'(hs_low_bad), 0);
        chk("b_max_h", 32'(max_h), 13);
        chk("b_max_v", 32'(max_v), 6);
        chk("b_wrap_h", 32'(h_b), 0);
        chk("b_wrap_v", 32'(v_b), 0);

        // Reset during VS aborts the frame
        for (int i = 0; i < 200 && !(h_b == 12'd6 && v_b == 12'd5); i++) tick_b(1'b0, 1'b1);
        chk("b_in_vs", 32'(vs_b), 0);
        tick_b(1'b1, 1'b1);
        chk("b_rst_h", 32'(h_b), 0);
        chk("b_rst_v", 32'(v_b), 0);
        chk("b_rst_vs", 32'(vs_b), 1);
        chk("b_rst_hs", 32'(hs_b), 1);
        n = -1;
        for (int i = 1; i <= 200 && n < 0; i++) begin
            tick_b(1'b0, 1'b1);
            if (fe_b) n = i;
        end
        chk("b_fe_after_rst", 32'(n), 97);
        tick_b(1'b0, 1'b1);
        chk("b_fe_wrap_h", 32'(h_b), 0);
        chk("b_fe_wrap_v", 32'(v_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
